// File: rtl/opr_execute_sequencer.sv
// Sequences one PDP-8 operate instruction around the micro-instruction decoder:
// latch operands, let the decode settle, capture AC/L/skip, apply OSR/HLT, hand back next PC.
module opr_execute_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit OSR_ENABLE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        opr_valid,
  output logic        opr_ready,
  input  logic [11:0] instr,
  input  logic [11:0] pc_in,
  input  logic [11:0] ac_in,
  input  logic        l_in,
  input  logic [11:0] sr,
  output logic [8:0]  i_reg,
  output logic [11:0] ac_reg,
  output logic        l_reg,
  input  logic [11:0] ac_micro,
  input  logic        l_micro,
  input  logic        skip,
  input  logic        micro_g1,
  input  logic        micro_g2,
  input  logic        micro_g3,
  output logic        done,
  input  logic        done_ack,
  output logic [11:0] ac_out,
  output logic        l_out,
  output logic [11:0] pc_out,
  output logic        halt,
  output logic        decode_err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WRITEBACK,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [8:0]  r_i_reg;
  logic [11:0] r_ac_reg;
  logic        r_l_reg;
  logic [11:0] r_pc;
  logic [11:0] r_sr;
  logic [11:0] r_ac_out;
  logic        r_l_out;
  logic [11:0] r_pc_out;
  logic        r_done;
  logic        r_halt;
  logic        r_decode_err;

  logic [2:0]  w_flags;
  logic        w_onehot;
  logic [11:0] w_pc_inc;
  logic [11:0] w_pc_skip;
  logic [11:0] w_osr;
  logic        w_accept;

  assign w_flags   = {micro_g1, micro_g2, micro_g3};
  assign w_onehot  = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
  // 12-bit adds wrap naturally: 7777 -> 0000 (no skip) or 0001 (skip)
  assign w_pc_inc  = r_pc + 12'd1;
  assign w_pc_skip = r_pc + 12'd2;
  assign w_osr     = (OSR_ENABLE && r_i_reg[2]) ? r_sr : 12'd0;
  assign w_accept  = opr_valid && opr_ready;

  assign opr_ready  = (r_state == S_IDLE) && !rst;
  assign i_reg      = r_i_reg;
  assign ac_reg     = r_ac_reg;
  assign l_reg      = r_l_reg;
  assign done       = r_done;
  assign ac_out     = r_ac_out;
  assign l_out      = r_l_out;
  assign pc_out     = r_pc_out;
  assign halt       = r_halt;
  assign decode_err = r_decode_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_i_reg      <= 9'd0;
      r_ac_reg     <= 12'd0;
      r_l_reg      <= 1'b0;
      r_pc         <= 12'd0;
      r_sr         <= 12'd0;
      r_ac_out     <= 12'd0;
      r_l_out      <= 1'b0;
      r_pc_out     <= 12'd0;
      r_done       <= 1'b0;
      r_halt       <= 1'b0;
      r_decode_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_i_reg      <= instr[8:0];
            r_ac_reg     <= ac_in;
            r_l_reg      <= l_in;
            r_pc         <= pc_in;
            r_sr         <= sr;
            r_cnt        <= SETTLE_LOAD;
            r_decode_err <= 1'b0;
            r_state      <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_WRITEBACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_WRITEBACK: begin
          if (!w_onehot) begin
            // Ambiguous group decode: leave AC/L untouched and just step the PC
            r_decode_err <= 1'b1;
            r_ac_out     <= r_ac_reg;
            r_l_out      <= r_l_reg;
            r_pc_out     <= w_pc_inc;
          end else if (micro_g2) begin
            r_ac_out <= ac_micro | w_osr;
            r_l_out  <= l_micro;
            r_pc_out <= skip ? w_pc_skip : w_pc_inc;
            if (r_i_reg[1]) begin
              r_halt <= 1'b1;
            end
          end else begin
            r_ac_out <= ac_micro;
            r_l_out  <= l_micro;
            r_pc_out <= w_pc_inc;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          if (done_ack) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opr_execute_sequencer.sv
// Directed bench for opr_execute_sequencer with a small behavioural PDP-8 operate decoder
// whose group flags can be overridden to provoke decode errors.
module tb_opr_execute_sequencer;

  logic        clk;
  logic        rst;
  logic        opr_valid;
  logic        opr_ready;
  logic [11:0] instr;
  logic [11:0] pc_in;
  logic [11:0] ac_in;
  logic        l_in;
  logic [11:0] sr;
  logic [8:0]  i_reg;
  logic [11:0] ac_reg;
  logic        l_reg;
  logic [11:0] ac_micro;
  logic        l_micro;
  logic        skip;
  logic        micro_g1;
  logic        micro_g2;
  logic        micro_g3;
  logic        done;
  logic        done_ack;
  logic [11:0] ac_out;
  logic        l_out;
  logic [11:0] pc_out;
  logic        halt;
  logic        decode_err;

  int checks = 0;
  int errors = 0;

  logic        force_en;
  logic [2:0]  force_flags;

  logic [11:0] m_ac;
  logic        m_l;
  logic        m_skip;
  logic        m_g1;
  logic        m_g2;
  logic        m_g3;
  logic        m_cond;

  opr_execute_sequencer #(.SETTLE_CYCLES(1), .OSR_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .opr_valid(opr_valid), .opr_ready(opr_ready),
    .instr(instr), .pc_in(pc_in), .ac_in(ac_in), .l_in(l_in), .sr(sr),
    .i_reg(i_reg), .ac_reg(ac_reg), .l_reg(l_reg),
    .ac_micro(ac_micro), .l_micro(l_micro), .skip(skip),
    .micro_g1(micro_g1), .micro_g2(micro_g2), .micro_g3(micro_g3),
    .done(done), .done_ack(done_ack), .ac_out(ac_out), .l_out(l_out),
    .pc_out(pc_out), .halt(halt), .decode_err(decode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference operate decoder: group 1 (CLA CLL CMA CML IAC RAR RAL), group 2 skips/CLA, group 3 CLA
  always_comb begin
    m_ac   = ac_reg;
    m_l    = l_reg;
    m_skip = 1'b0;
    m_g1   = 1'b0;
    m_g2   = 1'b0;
    m_g3   = 1'b0;
    m_cond = 1'b0;
    if (!i_reg[8]) begin
      m_g1 = 1'b1;
      if (i_reg[7]) m_ac = 12'd0;
      if (i_reg[6]) m_l = 1'b0;
      if (i_reg[5]) m_ac = ~m_ac;
      if (i_reg[4]) m_l = ~m_l;
      if (i_reg[0]) {m_l, m_ac} = {m_l, m_ac} + 13'd1;
      if (i_reg[3]) {m_l, m_ac} = {m_ac[0], m_l, m_ac[11:1]};
      if (i_reg[2]) {m_l, m_ac} = {m_ac[11], m_ac[10:0], m_l};
    end else if (!i_reg[0]) begin
      m_g2   = 1'b1;
      m_cond = (i_reg[6] && ac_reg[11]) || (i_reg[5] && (ac_reg == 12'd0)) || (i_reg[4] && l_reg);
      m_skip = m_cond ^ i_reg[3];
      if (i_reg[7]) m_ac = 12'd0;
    end else begin
      m_g3 = 1'b1;
      if (i_reg[7]) m_ac = 12'd0;
    end
  end

  assign ac_micro = m_ac;
  assign l_micro  = m_l;
  assign skip     = m_skip;
  assign {micro_g1, micro_g2, micro_g3} = force_en ? force_flags : {m_g1, m_g2, m_g3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Offer one instruction, return edges from the accept edge (counted as 1) until done is seen
  task automatic run_op(input logic [11:0] ins, input logic [11:0] pc, input logic [11:0] ac,
                        input logic l, input logic [11:0] s, output int lat);
    int n;
    @(negedge clk);
    instr = ins; pc_in = pc; ac_in = ac; l_in = l; sr = s; opr_valid = 1'b1;
    n = 0;
    while (!opr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 opr_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (done || lat >= 40) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    done_ack = 1'b1;
    @(posedge clk);
    #1 done_ack = 1'b0;
    chk("done_clr", done, 0);
    chk("ready_back", opr_ready, 1);
  endtask

  int lat;

  initial begin
    rst = 1'b1; opr_valid = 1'b0; done_ack = 1'b0; force_en = 1'b0; force_flags = 3'b000;
    instr = '0; pc_in = '0; ac_in = '0; l_in = 1'b0; sr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", opr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_ac_out", ac_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_i_reg", i_reg, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", decode_err, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_ready", opr_ready, 1);

    // CLA IAC
    run_op(12'o7201, 12'o0100, 12'o1234, 1'b1, 12'o0, lat);
    chk("cla_iac_lat", lat, 3);
    chk("cla_iac_ireg", i_reg, 9'o201);
    chk("cla_iac_ac", ac_out, 12'o0001);
    chk("cla_iac_l", l_out, 1);
    chk("cla_iac_pc", pc_out, 12'o0101);
    chk("cla_iac_err", decode_err, 0);
    ack();

    // SZA taken / not taken
    run_op(12'o7440, 12'o0200, 12'o0000, 1'b0, 12'o0, lat);
    chk("sza0_pc", pc_out, 12'o0202);
    ack();
    run_op(12'o7440, 12'o0200, 12'o0001, 1'b0, 12'o0, lat);
    chk("sza1_pc", pc_out, 12'o0201);
    chk("sza1_ac", ac_out, 12'o0001);
    ack();

    // PC wrap with and without skip
    run_op(12'o7410, 12'o7777, 12'o0123, 1'b0, 12'o0, lat);
    chk("skp_wrap_pc", pc_out, 12'o0001);
    ack();
    run_op(12'o7000, 12'o7777, 12'o0123, 1'b1, 12'o0, lat);
    chk("nop_wrap_pc", pc_out, 12'o0000);
    chk("nop_ac", ac_out, 12'o0123);
    chk("nop_l", l_out, 1);
    ack();

    // OSR, then sticky HLT
    run_op(12'o7404, 12'o0300, 12'o0000, 1'b0, 12'o5252, lat);
    chk("osr_ac", ac_out, 12'o5252);
    chk("osr_nohalt", halt, 0);
    ack();
    run_op(12'o7402, 12'o0301, 12'o0007, 1'b0, 12'o0, lat);
    chk("hlt_halt", halt, 1);
    chk("hlt_pc", pc_out, 12'o0302);
    ack();
    run_op(12'o7000, 12'o0302, 12'o0007, 1'b0, 12'o0, lat);
    chk("hlt_sticky", halt, 1);
    ack();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("hlt_cleared", halt, 0);

    // Forced non-one-hot group flags
    force_en = 1'b1; force_flags = 3'b000;
    run_op(12'o7201, 12'o0500, 12'o1234, 1'b1, 12'o0, lat);
    chk("err000_flag", decode_err, 1);
    chk("err000_ac", ac_out, 12'o1234);
    chk("err000_l", l_out, 1);
    chk("err000_pc", pc_out, 12'o0501);
    ack();
    force_flags = 3'b110;
    run_op(12'o7440, 12'o0600, 12'o0000, 1'b0, 12'o0, lat);
    chk("err110_flag", decode_err, 1);
    chk("err110_ac", ac_out, 12'o0000);
    chk("err110_pc", pc_out, 12'o0601);
    ack();
    force_en = 1'b0;
    run_op(12'o7040, 12'o0700, 12'o1234, 1'b0, 12'o0, lat);
    chk("err_cleared", decode_err, 0);
    chk("cma_ac", ac_out, 12'o6543);

    // Stall in DONE with a competing offer
    @(negedge clk);
    instr = 12'o7200; ac_in = 12'o1111; pc_in = 12'o4000; opr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_done", done, 1);
      chk("hold_ac", ac_out, 12'o6543);
      chk("hold_ireg", i_reg, 9'o040);
    end
    opr_valid = 1'b0;
    ack();

    // Reset in DECODE aborts the operation
    @(negedge clk);
    instr = 12'o7201; pc_in = 12'o1000; ac_in = 12'o0055; l_in = 1'b1; opr_valid = 1'b1;
    @(posedge clk);
    #1 opr_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", done, 0);
    chk("abort_ready_in_rst", opr_ready, 0);
    chk("abort_ireg", i_reg, 0);
    chk("abort_acreg", ac_reg, 0);
    chk("abort_ac_out", ac_out, 0);
    chk("abort_pc_out", pc_out, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("abort_ready", opr_ready, 1);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
